// File: rtl/da_shift_acc_if.sv
// da_shift_acc_if
// Bundles the LUT-side plane inputs and the result handshake of da_shift_acc.
//   master : drives start, B_temp, gen_done, a0_bit, t, lut_in, out_ready
//            and observes busy, out_valid, acc_out, t_err
//   slave  : the shift-accumulate stage itself (opposite directions)
// B_temp is flattened: element k occupies bits [k*DATA_WIDTH_B +: DATA_WIDTH_B].
interface da_shift_acc_if #(
    parameter int DATA_WIDTH_A = 8,
    parameter int DATA_WIDTH_B = 8,
    parameter int K            = 4,
    parameter int LUT_WIDTH    = DATA_WIDTH_B + $clog2(K),
    parameter int ACC_WIDTH    = LUT_WIDTH + DATA_WIDTH_A + 2
);
    logic                          start;
    logic [K*DATA_WIDTH_B-1:0]     B_temp;
    logic                          gen_done;
    logic                          a0_bit;
    logic [7:0]                    t;
    logic signed [LUT_WIDTH:0]     lut_in;
    logic                          busy;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [ACC_WIDTH-1:0]   acc_out;
    logic                          t_err;

    modport master (
        output start, B_temp, gen_done, a0_bit, t, lut_in, out_ready,
        input  busy, out_valid, acc_out, t_err
    );

    modport slave (
        input  start, B_temp, gen_done, a0_bit, t, lut_in, out_ready,
        output busy, out_valid, acc_out, t_err
    );
endinterface

// File: rtl/da_shift_acc.sv
// da_shift_acc
// Bit-serial shift-accumulate stage behind the distributed-arithmetic LUT.
// One signed LUT partial sum arrives per activation bit-plane, LSB first.
// The block undoes the A0 address conditioning (sign flip), weights each
// plane by 2^p (negative weight for the MSB plane) and starts from the
// offset-binary correction -S2, S2 = sum(B[k]>>>1). The final value is
// 2*sum((B[k]>>>1)*A[k]), held behind a valid/ready handshake.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : da_shift_acc_if.slave (start/B_temp/gen_done/a0_bit/t/lut_in
//              in, busy/out_valid/acc_out/t_err out, out_ready in)
// Optional feature: define DA_SHIFT_ACC_TCHECK_EN to check the plane index t
// against the internal plane counter (sticky t_err). Undefined: t_err = 0.
module da_shift_acc #(
    parameter int DATA_WIDTH_A = 8,
    parameter int DATA_WIDTH_B = 8,
    parameter int K            = 4,
    parameter int LUT_WIDTH    = DATA_WIDTH_B + $clog2(K),
    parameter int ACC_WIDTH    = LUT_WIDTH + DATA_WIDTH_A + 2
) (
    input  logic           clk,
    input  logic           rst,
    da_shift_acc_if.slave  bus
);
    localparam int PW = (DATA_WIDTH_A > 1) ? $clog2(DATA_WIDTH_A) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DATA_WIDTH_A - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]                  state_r;
    logic [PW-1:0]               p_r;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic signed [ACC_WIDTH-1:0] acc_out_r;
    logic                        busy_r;
    logic                        out_valid_r;

    logic signed [ACC_WIDTH-1:0] s2_s;
    logic signed [ACC_WIDTH-1:0] term_s;
    logic signed [ACC_WIDTH-1:0] shifted_s;
    logic signed [ACC_WIDTH-1:0] acc_plane_s;
    logic                        plane_accept_s;
    logic                        last_plane_s;

    // Offset-binary correction: sum of halved weights, sign-extended.
    function automatic logic signed [ACC_WIDTH-1:0] half_sum(
        input logic [K*DATA_WIDTH_B-1:0] b
    );
        logic signed [ACC_WIDTH-1:0]    s;
        logic signed [DATA_WIDTH_B-1:0] e;
        logic signed [DATA_WIDTH_B-1:0] h;
        s = '0;
        for (int k = 0; k < K; k++) begin
            e = b[k*DATA_WIDTH_B +: DATA_WIDTH_B];
            h = e >>> 1;
            s = s + {{(ACC_WIDTH-DATA_WIDTH_B){h[DATA_WIDTH_B-1]}}, h};
        end
        return s;
    endfunction

    // Sign-extend a LUT partial sum to accumulator width.
    function automatic logic signed [ACC_WIDTH-1:0] sext_lut(
        input logic signed [LUT_WIDTH:0] v
    );
        return {{(ACC_WIDTH-LUT_WIDTH-1){v[LUT_WIDTH]}}, v};
    endfunction

    // Plane datapath: sign flip, 2^p weighting, MSB plane subtracts.
    always_comb begin
        s2_s           = half_sum(bus.B_temp);
        plane_accept_s = (state_r == ST_ACC) & bus.gen_done;
        last_plane_s   = (p_r == P_LAST);
        // Extend before negating so the most negative LUT value cannot wrap.
        if (bus.a0_bit) begin
            term_s = sext_lut(bus.lut_in);
        end else begin
            term_s = -sext_lut(bus.lut_in);
        end
        shifted_s = term_s <<< p_r;
        if (last_plane_s) begin
            acc_plane_s = acc_r - shifted_s;
        end else begin
            acc_plane_s = acc_r + shifted_s;
        end
    end

    // Control FSM, accumulator, plane counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            p_r         <= '0;
            acc_r       <= '0;
            acc_out_r   <= '0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc_r   <= -s2_s;
                        p_r     <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_ACC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACC: begin
                    if (plane_accept_s) begin
                        acc_r <= acc_plane_s;
                        if (last_plane_s) begin
                            // Counter returns to 0 so non-power-of-two W needs no wrap.
                            p_r         <= '0;
                            acc_out_r   <= acc_plane_s;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_HOLD;
                        end else begin
                            p_r <= p_r + 1'b1;
                        end
                    end else begin
                        state_r <= ST_ACC;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    p_r         <= '0;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.acc_out   = acc_out_r;

`ifdef DA_SHIFT_ACC_TCHECK_EN
    logic t_err_r;

    // Sticky plane-order flag: set when an accepted plane's t differs from p.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_err_r <= 1'b0;
        end else if (plane_accept_s && (bus.t != 8'(p_r))) begin
            t_err_r <= 1'b1;
        end else begin
            t_err_r <= t_err_r;
        end
    end

    assign bus.t_err = t_err_r;
`else
    logic [7:0] unused_t_s;
    assign unused_t_s = bus.t;
    assign bus.t_err  = 1'b0;
`endif

endmodule
